pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 16, number of refclk cycles pll_rst is held high per sequence; legal range 1..255.
REQ-002 Parameter LOCK_FILTER, default 64, consecutive synchronized-locked cycles required before release; legal range 1..1023.
REQ-003 Parameter LOCK_TIMEOUT, default 50000, WAIT_LOCK cycles (1 ms at 50 MHz) before a retry.
REQ-004 Parameter MAX_RETRIES, default 3, consecutive lock timeouts that trigger FAULT.
REQ-005 refclk  input  1  sole clock, 50 MHz PLL reference; every flop in the block is clocked on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 locked  input  1  PLL lock indication, asynchronous to refclk.
REQ-008 restart  input  1  single-cycle request to re-run the full PLL reset sequence.
REQ-009 clear_fault  input  1  single-cycle request to leave FAULT.
REQ-010 pll_rst  output  1  active-high reset driven to the PLL.
REQ-011 sys_rst_n  output  1  active-low reset for logic in the PLL output domain.
REQ-012 ready  output  1  high only in RUN.
REQ-013 fault  output  1  high only in FAULT.
REQ-014 relock_count  output  8  number of lock losses seen in RUN; saturates at 255.
REQ-015 state  output  3  current state encoding, for debug.

Function
REQ-016 locked SHALL pass through a 2-flop synchronizer before use (locked_sync); no other logic SHALL sample raw locked.
REQ-017 States SHALL be RESET_PLL, WAIT_LOCK, RUN, FAULT; all outputs SHALL be registered and decoded from the registered state.
REQ-018 RESET_PLL: pll_rst=1, sys_rst_n=0, ready=0; after exactly PLL_RST_CYCLES cycles in the state → WAIT_LOCK.
REQ-019 WAIT_LOCK: pll_rst=0, sys_rst_n=0; filter counter increments on each locked_sync=1 cycle and clears to 0 on any locked_sync=0 cycle.
REQ-020 WAIT_LOCK: when the filter count reaches LOCK_FILTER → RUN and clear the retry count; the first RUN cycle has ready=1 and sys_rst_n=1.
REQ-021 WAIT_LOCK: the timeout counter counts every cycle; on reaching LOCK_TIMEOUT the retry count increments, then the block goes → FAULT if retry count = MAX_RETRIES, else → RESET_PLL.
REQ-022 RUN: locked_sync=0 → RESET_PLL on the next edge; relock_count increments (saturating) in the same edge.
REQ-023 restart=1 in RESET_PLL, WAIT_LOCK or RUN SHALL force → RESET_PLL, restart the PLL_RST_CYCLES count, and clear the retry count; restart SHALL be ignored in FAULT.
REQ-024 restart and lock loss in the same RUN cycle: restart has priority, and relock_count SHALL NOT increment.
REQ-025 FAULT: pll_rst=1, sys_rst_n=0, fault=1; clear_fault=1 → RESET_PLL with retry count cleared; clear_fault SHALL be ignored outside FAULT.
REQ-026 All counters SHALL clear on every state entry, and no counter SHALL wrap.

Reset
REQ-027 rst=0 sampled on a refclk edge SHALL force, on that edge: state=RESET_PLL, pll_rst=1, sys_rst_n=0, ready=0, fault=0, relock_count=0, and all counters and synchronizer flops cleared.
REQ-028 rst=0 asserted mid-sequence, including in RUN or FAULT, SHALL abort the sequence with no partial state retained; a fresh sequence starts on the first edge with rst=1.

Structure
REQ-029 Package pll_seq_pkg SHALL hold the state enum, the 3-bit encodings (RESET_PLL=0, WAIT_LOCK=1, RUN=2, FAULT=3) and the default parameter constants.
REQ-030 The synchronizer SHALL be the sub-module sync_2ff (1-bit, refclk, synchronous active-low reset); the rest of the block is a single FSM with its counters.

Verification
REQ-031 Release rst with locked tied high → pll_rst high for 16 cycles, then ready=1 and sys_rst_n=1 exactly 64 cycles after locked_sync is first seen high in WAIT_LOCK.
REQ-032 locked toggles low once, 30 cycles into WAIT_LOCK → filter restarts; ready rises 64 locked_sync-high cycles after that glitch.
REQ-033 locked held low → three 50000-cycle timeouts with RESET_PLL between them, then fault=1 and pll_rst=1; clear_fault → RESET_PLL with fault=0.
REQ-034 In RUN, drop locked for 1 cycle, 300 times → 300 resequences, relock_count=255 (saturated).
REQ-035 restart and locked drop in the same RUN cycle → RESET_PLL and relock_count unchanged; restart pulsed in FAULT → state remains FAULT.
REQ-036 rst pulsed low in RUN with relock_count=5 → next edge shows state=0, relock_count=0, sys_rst_n=0, pll_rst=1.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding and default timing constants for the PLL reset sequencer
//
// Purpose : state enum with fixed 3-bit debug encodings, default parameter
//           values, and a saturating 8-bit increment helper.
// Ports   : none (package)

package pll_seq_pkg;

    // Encodings are fixed because the state is exported on a debug port.
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        RUN       = 3'd2,
        FAULT     = 3'd3
    } pll_state_e;

    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_FILTER    = 64;
    localparam int DEF_LOCK_TIMEOUT   = 50000;  // 1 ms at 50 MHz
    localparam int DEF_MAX_RETRIES    = 3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer into the refclk domain
//
// Purpose : bring an asynchronous level into refclk; both flops clear on reset.
// Ports   : refclk  - destination clock
//           rst     - synchronous active-low reset
//           i_d     - asynchronous input level
//           o_q     - synchronized level (two refclk edges of latency)

module sync_2ff (
    input  logic refclk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge refclk) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset / lock-qualify / retry sequencer with fault latch
//
// Purpose : holds the PLL in reset, waits for a filtered lock, releases the
//           output-domain reset, retries on lock timeout, latches a fault
//           after MAX_RETRIES consecutive timeouts, and resequences on lock loss.
// Ports   : refclk       - sole clock (PLL reference)
//           rst          - synchronous active-low reset
//           locked       - PLL lock, asynchronous (synchronized internally)
//           restart      - one-cycle request to rerun the sequence (ignored in FAULT)
//           clear_fault  - one-cycle request to leave FAULT
//           pll_rst      - active-high PLL reset
//           sys_rst_n    - active-low reset for the PLL output domain
//           ready        - high only in RUN
//           fault        - high only in FAULT
//           relock_count - lock losses seen in RUN, saturating at 255
//           state        - current state encoding

module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       restart,
    input  logic       clear_fault,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [7:0] relock_count,
    output logic [2:0] state
);

    localparam int CNT_W = $clog2(PLL_RST_CYCLES + 1);
    localparam int FLT_W = $clog2(LOCK_FILTER + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    pll_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [FLT_W-1:0] r_filt;
    logic [TMO_W-1:0] r_tmo;
    logic [RTY_W-1:0] r_retry;
    logic [7:0]       r_relock;
    logic             r_pll_rst;
    logic             r_sys_rst_n;
    logic             r_ready;
    logic             r_fault;

    logic             w_locked_sync;
    pll_state_e       w_next_state;
    logic [FLT_W-1:0] w_filt_inc;
    logic [TMO_W-1:0] w_tmo_inc;
    logic [RTY_W-1:0] w_retry_inc;
    logic             w_restart;
    logic             w_lock_done;
    logic             w_timeout;
    logic             w_enter;
    logic             w_lock_lost;

    sync_2ff u_sync_locked (
        .refclk (refclk),
        .rst    (rst),
        .i_d    (locked),
        .o_q    (w_locked_sync)
    );

    assign w_filt_inc  = r_filt + FLT_W'(1);
    assign w_tmo_inc   = r_tmo + TMO_W'(1);
    assign w_retry_inc = r_retry + RTY_W'(1);

    // restart is honoured everywhere except FAULT, and beats every other exit.
    assign w_restart   = restart && (r_state != FAULT);

    // Lock qualification wins over a timeout landing on the same cycle.
    assign w_lock_done = (r_state == WAIT_LOCK) && !w_restart && w_locked_sync &&
                         (w_filt_inc == FLT_W'(LOCK_FILTER));
    assign w_timeout   = (r_state == WAIT_LOCK) && !w_restart && !w_lock_done &&
                         (w_tmo_inc == TMO_W'(LOCK_TIMEOUT));
    assign w_lock_lost = (r_state == RUN) && !w_restart && !w_locked_sync;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RESET_PLL: begin
                if (!w_restart && (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)))
                    w_next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (w_restart)
                    w_next_state = RESET_PLL;
                else if (w_lock_done)
                    w_next_state = RUN;
                else if (w_timeout)
                    w_next_state = (w_retry_inc == RTY_W'(MAX_RETRIES)) ? FAULT : RESET_PLL;
            end
            RUN: begin
                if (w_restart || w_lock_lost)
                    w_next_state = RESET_PLL;
            end
            FAULT: begin
                if (clear_fault)
                    w_next_state = RESET_PLL;
            end
            default: w_next_state = RESET_PLL;
        endcase
    end

    // A restart inside RESET_PLL does not change state but must still rerun
    // the full hold count, so it counts as a state entry.
    assign w_enter = w_restart || (w_next_state != r_state);

    always_ff @(posedge refclk) begin
        if (!rst) begin
            r_state     <= RESET_PLL;
            r_cnt       <= '0;
            r_filt      <= '0;
            r_tmo       <= '0;
            r_retry     <= '0;
            r_relock    <= 8'd0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_enter) begin
                r_cnt  <= '0;
                r_filt <= '0;
                r_tmo  <= '0;
            end else begin
                case (r_state)
                    RESET_PLL: r_cnt <= r_cnt + CNT_W'(1);
                    WAIT_LOCK: begin
                        r_filt <= w_locked_sync ? w_filt_inc : '0;
                        r_tmo  <= w_tmo_inc;
                    end
                    default: ;
                endcase
            end

            // Retry count tracks consecutive timeouts; it survives the
            // RESET_PLL re-entry between retries and sticks at MAX_RETRIES in FAULT.
            if (w_restart || w_lock_done || ((r_state == FAULT) && clear_fault))
                r_retry <= '0;
            else if (w_timeout)
                r_retry <= w_retry_inc;

            if (w_lock_lost)
                r_relock <= sat_inc8(r_relock);

            // Outputs decode the state being entered so they line up with r_state.
            r_pll_rst   <= (w_next_state == RESET_PLL) || (w_next_state == FAULT);
            r_sys_rst_n <= (w_next_state == RUN);
            r_ready     <= (w_next_state == RUN);
            r_fault     <= (w_next_state == FAULT);
        end
    end

    assign pll_rst      = r_pll_rst;
    assign sys_rst_n    = r_sys_rst_n;
    assign ready        = r_ready;
    assign fault        = r_fault;
    assign relock_count = r_relock;
    assign state        = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer

module tb_pll_reset_sequencer;

    localparam int T_RST  = 16;
    localparam int T_FILT = 64;
    localparam int T_TMO  = 500;

    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       locked = 1'b0;
    logic       restart = 1'b0;
    logic       clear_fault = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [7:0] relock_count;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (T_RST),
        .LOCK_FILTER    (T_FILT),
        .LOCK_TIMEOUT   (T_TMO),
        .MAX_RETRIES    (3)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .locked       (locked),
        .restart      (restart),
        .clear_fault  (clear_fault),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .fault        (fault),
        .relock_count (relock_count),
        .state        (state)
    );

    always #10 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(3);
        rst = 1'b1;
    endtask

    task automatic wait_ready(input int bound, output int n);
        n = 0;
        while (!ready && n < bound) begin
            n++;
            step(1);
        end
    endtask

    // One-cycle lock drop in RUN; ok=1 when ready fell and came back.
    task automatic drop_once(output int ok);
        int n;
        int m;
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        n = 0;
        while (ready && n < 10) begin
            n++;
            step(1);
        end
        wait_ready(200, m);
        ok = (n < 10 && m < 200) ? 1 : 0;
    endtask

    initial begin
        int n;
        int ok;
        int reseq;

        // Power-up with lock already asserted.
        locked = 1'b1;
        do_reset();
        check("rst_state", state, 0);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_sys_rst_n", sys_rst_n, 0);
        check("rst_ready", ready, 0);
        check("rst_fault", fault, 0);
        check("rst_relock", relock_count, 0);
        n = 0;
        while (pll_rst && n < 100) begin
            n++;
            step(1);
        end
        check("pll_rst_len", n, T_RST);
        check("wait_lock_state", state, 1);
        wait_ready(200, n);
        check("filter_len", n, T_FILT);
        check("run_sys_rst_n", sys_rst_n, 1);
        check("run_pll_rst", pll_rst, 0);
        check("run_state", state, 2);

        // restart coinciding with the lock-loss cycle.
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(1);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("restart_prio_state", state, 0);
        check("restart_prio_relock", relock_count, 0);
        n = 0;
        while (pll_rst && n < 100) begin
            n++;
            step(1);
        end
        check("restart_full_hold", n, T_RST);

        // Lock glitch 30 cycles into WAIT_LOCK restarts the filter.
        do_reset();
        step(T_RST);
        check("glitch_wait_state", state, 1);
        step(30);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        wait_ready(200, n);
        check("glitch_ready_delay", n, 2 + T_FILT);

        // Five lock drops, then reset in RUN.
        reseq = 0;
        for (int i = 0; i < 5; i++) begin
            drop_once(ok);
            reseq += ok;
        end
        check("drop5_reseq", reseq, 5);
        check("drop5_relock", relock_count, 5);
        check("drop5_state", state, 2);
        rst = 1'b0;
        step(1);
        check("midrun_rst_state", state, 0);
        check("midrun_rst_relock", relock_count, 0);
        check("midrun_rst_sys_rst_n", sys_rst_n, 0);
        check("midrun_rst_pll_rst", pll_rst, 1);
        check("midrun_rst_ready", ready, 0);
        rst = 1'b1;
        wait_ready(200, n);
        check("rerun_ready", ready, 1);

        // 300 lock drops saturate the relock counter.
        reseq = 0;
        for (int i = 0; i < 300; i++) begin
            drop_once(ok);
            reseq += ok;
            if (i == 254) check("relock_at_255", relock_count, 255);
        end
        check("drop300_reseq", reseq, 300);
        check("drop300_relock_sat", relock_count, 255);

        // Lock never arrives: three timeouts, then FAULT.
        locked = 1'b0;
        do_reset();
        step(T_RST);
        check("tmo1_wait", state, 1);
        step(T_TMO - 1);
        check("tmo1_last_cycle", state, 1);
        step(1);
        check("tmo1_retry", state, 0);
        step(T_RST);
        step(T_TMO);
        check("tmo2_retry", state, 0);
        step(T_RST);
        step(T_TMO);
        check("tmo3_state", state, 3);
        check("tmo3_fault", fault, 1);
        check("tmo3_pll_rst", pll_rst, 1);
        check("tmo3_sys_rst_n", sys_rst_n, 0);
        check("tmo3_ready", ready, 0);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        step(2);
        check("fault_ignores_restart", state, 3);
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        check("clear_fault_state", state, 0);
        check("clear_fault_flag", fault, 0);

        // Two timeouts, then restart clears the retry count.
        step(T_RST);
        step(T_TMO);
        check("cf_tmo1", state, 0);
        step(T_RST);
        step(T_TMO);
        check("cf_tmo2", state, 0);
        step(T_RST);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("restart_in_wait", state, 0);
        step(T_RST);
        step(T_TMO);
        check("restart_clears_retry", state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
